// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  // Operand source selects, as registered into EX timing
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file
  localparam logic [1:0] FWD_EX   = 2'b10;  // EX/MEM result
  localparam logic [1:0] FWD_MEM  = 2'b01;  // MEM/WB write-back value

  // Memory-wait controller state
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_compare.sv
// Per-source compare: next forwarding select and load-use hit for one ID operand.
// Latency: combinational.
// Backpressure: none; the top decides when the result is registered.
module fwd_compare
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_rw,
  input  logic              i_ex_ld,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_rw,
  output logic [1:0]        o_nxt_sel,
  output logic              o_lu_hit
);

  logic w_ex_hit;
  logic w_mem_hit;

  // Register 0 is hardwired zero, so it never matches a producer
  assign w_ex_hit  = i_use && i_ex_rw  && (i_ex_rd  != '0) && (i_ex_rd  == i_src);
  assign w_mem_hit = i_use && i_mem_rw && (i_mem_rd != '0) && (i_mem_rd == i_src);

  // Youngest producer (EX/MEM) wins over the older one (MEM/WB)
  always_comb begin
    o_nxt_sel = FWD_NONE;
    if (w_ex_hit)       o_nxt_sel = FWD_EX;
    else if (w_mem_hit) o_nxt_sel = FWD_MEM;
  end

  // A load in ID/EX cannot forward its data in time: one bubble needed
  assign o_lu_hit = w_ex_hit && i_ex_ld;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects (computed at ID, registered to EX), operand muxes, load-use and memory-wait stalls.
// Latency: selects 1 cycle ID->EX; operand mux and stall outputs combinational.
// Backpressure: stall_all freezes on a pending load miss (bounded by MAX_WAIT); stall_id/bubble_ex on load-use.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int DATA_W   = 16,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_use,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_rw,
  input  logic                      ex_ld,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_rw,
  input  logic                      mem_ld,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_res,
  input  logic [DATA_W-1:0]         wb_res,
  input  logic [NUM_SRC*DATA_W-1:0] rf_data,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] opnd,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      stall_all,
  output logic                      mem_err,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [NUM_SRC*2-1:0] r_fwd_sel;
  logic [NUM_SRC*2-1:0] w_nxt_sel;
  logic [NUM_SRC-1:0]   w_lu_vec;
  logic                 w_lu;
  logic                 w_timeout;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [WAIT_W-1:0]    w_wait_nxt;
  logic                 w_err_set;
  logic                 r_mem_err;
  logic [CNT_W-1:0]     r_stall_cnt;

  // One comparator and one operand mux per source channel
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_compare #(.REG_AW(REG_AW)) u_cmp (
      .i_src     (id_src[g*REG_AW +: REG_AW]),
      .i_use     (id_use[g]),
      .i_ex_rd   (ex_rd),
      .i_ex_rw   (ex_rw),
      .i_ex_ld   (ex_ld),
      .i_mem_rd  (mem_rd),
      .i_mem_rw  (mem_rw),
      .o_nxt_sel (w_nxt_sel[g*2 +: 2]),
      .o_lu_hit  (w_lu_vec[g])
    );

    assign opnd[g*DATA_W +: DATA_W] =
      (r_fwd_sel[g*2 +: 2] == FWD_EX)  ? mem_res :
      (r_fwd_sel[g*2 +: 2] == FWD_MEM) ? wb_res  :
                                         rf_data[g*DATA_W +: DATA_W];
  end

  assign w_lu = |w_lu_vec;

  // The final wait cycle releases the freeze so the pipe can move on with mem_err flagged
  assign w_timeout = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign stall_all = mem_ld && !mem_ready && !w_timeout;
  assign stall_id  = w_lu && !flush && !stall_all;
  assign bubble_ex = (w_lu || flush) && !stall_all;

  // Selects hold under a freeze, clear for a bubble, otherwise track ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_fwd_sel <= '0;
    else if (stall_all)       r_fwd_sel <= r_fwd_sel;
    else if (flush || w_lu)   r_fwd_sel <= '0;
    else                      r_fwd_sel <= w_nxt_sel;
  end

  // Memory-wait controller: next state, wait counter and timeout flag
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_ld && !mem_ready) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt = RUN;
        end else if (w_timeout) begin
          w_state_nxt = RUN;
          w_err_set   = 1'b1;
        end else begin
          w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State, wait counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
    end
  end

  // Saturating stall-cycle counter; a clear beats a concurrent increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_stall_cnt <= '0;
    else if (cnt_clr)                                 r_stall_cnt <= '0;
    else if ((stall_all || stall_id) && (r_stall_cnt != '1))
                                                      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign fwd_sel   = r_fwd_sel;
  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule
